// File: rtl/vga_fb_write_arbiter_if.sv
// rtl/vga_fb_write_arbiter_if.sv - requester and framebuffer write bus of the arbiter
interface vga_fb_write_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 3
);
  logic                     display;
  logic                     vga_VS;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*X_W-1:0]     req_x;
  logic [N_REQ*Y_W-1:0]     req_y;
  logic [N_REQ*COLOR_W-1:0] req_color;
  logic [N_REQ-1:0]         ack;
  logic [N_REQ-1:0]         grant;
  logic                     fb_we;
  logic [ADDR_W-1:0]        fb_addr;
  logic [COLOR_W-1:0]       fb_wdata;
  logic                     clipped;
  logic                     frame_start;

  // Drawing engines plus VGA timing side.
  modport master (
    output display, vga_VS, req, req_x, req_y, req_color,
    input  ack, grant, fb_we, fb_addr, fb_wdata, clipped, frame_start
  );

  // Arbiter side.
  modport slave (
    input  display, vga_VS, req, req_x, req_y, req_color,
    output ack, grant, fb_we, fb_addr, fb_wdata, clipped, frame_start
  );
endinterface

// File: rtl/vga_fb_write_arbiter.sv
// rtl/vga_fb_write_arbiter.sv - round-robin burst arbiter for the framebuffer write port
module vga_fb_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 160,
  parameter int HEIGHT    = 120,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int ADDR_W    = 15,
  parameter int COLOR_W   = 3,
  parameter int MAX_BURST = 16
) (
  input logic                  clk,
  input logic                  resetn,
  vga_fb_write_arbiter_if.slave bus
);
  localparam int IDX_W  = $clog2(N_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);
  localparam logic [X_W:0]      X_LIM    = (X_W + 1)'(WIDTH);
  localparam logic [Y_W:0]      Y_LIM    = (Y_W + 1)'(HEIGHT);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]  ONE      = N_REQ'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   pick;
  logic               pick_valid;
  logic [BEAT_W-1:0]  beat;
  logic               vs_d;
  logic               window;
  logic               xfer;
  logic               in_range;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [COLOR_W-1:0] sel_color;

  // Writes only happen while the scan is outside the colour region.
  assign window    = ~bus.display;
  assign sel_x     = bus.req_x[owner*X_W +: X_W];
  assign sel_y     = bus.req_y[owner*Y_W +: Y_W];
  assign sel_color = bus.req_color[owner*COLOR_W +: COLOR_W];
  assign xfer      = (state == GRANT) & window & bus.req[owner] & (beat < BEAT_MAX);
  assign in_range  = ({1'b0, sel_x} < X_LIM) & ({1'b0, sel_y} < Y_LIM);

  // Ready goes only to the current owner; a transfer is exactly owner ready & valid.
  always_comb begin
    bus.ack        = '0;
    bus.ack[owner] = xfer;
  end

  // Round-robin search starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    int cand;
    pick       = '0;
    pick_valid = 1'b0;
    cand       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!pick_valid && bus.req[IDX_W'(cand)]) begin
        pick       = IDX_W'(cand);
        pick_valid = 1'b1;
      end
    end
  end

  // Grant FSM; any GRANT cycle without a transfer is a release condition.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      bus.grant <= '0;
      ptr       <= '0;
      owner     <= '0;
      beat      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (window && pick_valid) begin
            state     <= GRANT;
            bus.grant <= ONE << pick;
            owner     <= pick;
            beat      <= '0;
          end else begin
            bus.grant <= '0;
          end
        end
        GRANT: begin
          if (xfer) begin
            beat <= beat + BEAT_W'(1);
          end else begin
            state     <= IDLE;
            bus.grant <= '0;
            ptr       <= (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered write port: one cycle from transfer to fb_we, out-of-range pixels are dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.fb_we    <= 1'b0;
      bus.fb_addr  <= '0;
      bus.fb_wdata <= '0;
      bus.clipped  <= 1'b0;
    end else begin
      bus.fb_we   <= xfer & in_range;
      bus.clipped <= xfer & ~in_range;
      if (xfer && in_range) begin
        bus.fb_addr  <= ADDR_W'(sel_y) * ADDR_W'(WIDTH) + ADDR_W'(sel_x);
        bus.fb_wdata <= sel_color;
      end
    end
  end

  // Frame tick on the falling edge of vertical sync, independent of arbitration.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vs_d            <= 1'b1;
      bus.frame_start <= 1'b0;
    end else begin
      vs_d            <= bus.vga_VS;
      bus.frame_start <= vs_d & ~bus.vga_VS;
    end
  end
endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// tb/tb_vga_fb_write_arbiter.sv - self-checking bench for vga_fb_write_arbiter
module tb_vga_fb_write_arbiter;
  localparam int N = 4, XW = 8, YW = 7, AW = 15, CW = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          display = 1'b1;
  logic          vs = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*XW-1:0] rx = '0;
  logic [N*YW-1:0] ry = '0;
  logic [N*CW-1:0] rc = '0;

  int vectors = 0;
  int errors  = 0;

  vga_fb_write_arbiter_if #(.N_REQ(N), .X_W(XW), .Y_W(YW), .ADDR_W(AW), .COLOR_W(CW)) bus0 ();
  vga_fb_write_arbiter_if #(.N_REQ(N), .X_W(XW), .Y_W(YW), .ADDR_W(AW), .COLOR_W(CW)) bus1 ();

  assign bus0.display = display;  assign bus1.display = display;
  assign bus0.vga_VS = vs;        assign bus1.vga_VS = vs;
  assign bus0.req = req;          assign bus1.req = req;
  assign bus0.req_x = rx;         assign bus1.req_x = rx;
  assign bus0.req_y = ry;         assign bus1.req_y = ry;
  assign bus0.req_color = rc;     assign bus1.req_color = rc;

  vga_fb_write_arbiter #(.N_REQ(N), .MAX_BURST(16)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  vga_fb_write_arbiter #(.N_REQ(N), .MAX_BURST(2))  dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  logic [N-1:0]  o_ack[2], o_grant[2];
  logic          o_we[2], o_clip[2], o_fs[2];
  logic [AW-1:0] o_addr[2];
  logic [CW-1:0] o_wd[2];
  assign o_ack[0] = bus0.ack;     assign o_ack[1] = bus1.ack;
  assign o_grant[0] = bus0.grant; assign o_grant[1] = bus1.grant;
  assign o_we[0] = bus0.fb_we;    assign o_we[1] = bus1.fb_we;
  assign o_clip[0] = bus0.clipped; assign o_clip[1] = bus1.clipped;
  assign o_fs[0] = bus0.frame_start; assign o_fs[1] = bus1.frame_start;
  assign o_addr[0] = bus0.fb_addr; assign o_addr[1] = bus1.fb_addr;
  assign o_wd[0] = bus0.fb_wdata;  assign o_wd[1] = bus1.fb_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int o);
    logic [N-1:0] r;
    r = '0;
    if (o >= 0) r[o] = 1'b1;
    return r;
  endfunction

  function automatic int oh2i(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Transaction-level model: owner index (-1 when idle), round-robin pointer, transfers in this grant.
  int            m_owner[2], m_ptr[2], m_beat[2];
  bit            m_vsd[2], e_we[2], e_clip[2], e_fs[2];
  logic [AW-1:0] e_addr[2];
  logic [CW-1:0] e_wd[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int mb, x, y, c, nxt;
      logic [N-1:0] eack;
      bit xf;
      mb = (k == 0) ? 16 : 2;
      if (!resetn) begin
        m_owner[k] = -1; m_ptr[k] = 0; m_beat[k] = 0; m_vsd[k] = 1'b1;
        e_we[k] = 1'b0; e_clip[k] = 1'b0; e_fs[k] = 1'b0; e_addr[k] = '0; e_wd[k] = '0;
      end
      eack = '0;
      if (m_owner[k] >= 0 && !display && req[m_owner[k]] && m_beat[k] < mb) eack[m_owner[k]] = 1'b1;
      chk($sformatf("ack[%0d]", k), 32'(o_ack[k]), 32'(eack));
      chk($sformatf("grant[%0d]", k), 32'(o_grant[k]), 32'(onehot(m_owner[k])));
      chk($sformatf("fb_we[%0d]", k), 32'(o_we[k]), 32'(e_we[k]));
      chk($sformatf("fb_addr[%0d]", k), 32'(o_addr[k]), 32'(e_addr[k]));
      chk($sformatf("fb_wdata[%0d]", k), 32'(o_wd[k]), 32'(e_wd[k]));
      chk($sformatf("clipped[%0d]", k), 32'(o_clip[k]), 32'(e_clip[k]));
      chk($sformatf("frame_start[%0d]", k), 32'(o_fs[k]), 32'(e_fs[k]));
      if (resetn) begin
        xf = (eack != '0);
        e_we[k] = 1'b0;
        e_clip[k] = 1'b0;
        if (xf) begin
          x = int'(rx[m_owner[k]*XW +: XW]);
          y = int'(ry[m_owner[k]*YW +: YW]);
          c = int'(rc[m_owner[k]*CW +: CW]);
          if (x < 160 && y < 120) begin
            e_we[k] = 1'b1;
            e_addr[k] = AW'(y * 160 + x);
            e_wd[k] = CW'(c);
          end else begin
            e_clip[k] = 1'b1;
          end
        end
        e_fs[k] = m_vsd[k] && !vs;
        m_vsd[k] = vs;
        if (m_owner[k] < 0) begin
          if (!display && req != '0) begin
            for (int i = 0; i < N; i++) begin
              nxt = (m_ptr[k] + i) % N;
              if (req[nxt] && m_owner[k] < 0) m_owner[k] = nxt;
            end
            m_beat[k] = 0;
          end
        end else if (xf) begin
          m_beat[k]++;
        end else begin
          m_ptr[k] = (m_owner[k] + 1) % N;
          m_owner[k] = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int i, input int x, input int y, input int c);
    rx[i*XW +: XW] = XW'(x);
    ry[i*YW +: YW] = YW'(y);
    rc[i*CW +: CW] = CW'(c);
  endtask

  task automatic rst();
    tick();
    resetn = 1'b0; req = '0; display = 1'b1; vs = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    int wcount;
    int seq[$];
    int wc[N];
    int idx;
    logic [N-1:0] prev;

    // Reset state
    rst();
    chk("reset_grant", 32'(o_grant[0]), 32'h0);
    chk("reset_we", 32'(o_we[0]), 32'h0);

    // Single requester, full 16-pixel burst
    set_px(0, 3, 2, 5); display = 1'b0; req = 4'b0001;
    tick();
    chk("t1_grant", 32'(o_grant[0]), 32'h1);
    chk("t1_ack", 32'(o_ack[0]), 32'h1);
    tick();
    chk("t1_we", 32'(o_we[0]), 32'h1);
    chk("t1_addr", 32'(o_addr[0]), 32'd323);
    chk("t1_wdata", 32'(o_wd[0]), 32'd5);
    wcount = 1;
    for (int i = 0; i < 15; i++) begin tick(); if (o_we[0]) wcount++; end
    chk("t1_writes", 32'(wcount), 32'd16);
    tick();
    chk("t1_idle_grant", 32'(o_grant[0]), 32'h0);
    chk("t1_idle_we", 32'(o_we[0]), 32'h0);
    tick();
    chk("t1_regrant", 32'(o_grant[0]), 32'h1);
    req = '0; display = 1'b1;

    // All requesters, MAX_BURST=2 instance
    rst();
    for (int i = 0; i < N; i++) set_px(i, i + 10, i, i + 1);
    req = 4'b1111; display = 1'b0;
    prev = '0;
    for (int i = 0; i < N; i++) wc[i] = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      idx = oh2i(o_grant[1]);
      if (o_grant[1] != '0 && prev == '0) seq.push_back(idx);
      if (o_we[1] && idx >= 0) wc[idx]++;
      prev = o_grant[1];
    end
    chk("t2_seq_len", 32'(seq.size()), 32'd5);
    if (seq.size() == 5) begin
      chk("t2_seq0", 32'(seq[0]), 32'd0);
      chk("t2_seq1", 32'(seq[1]), 32'd1);
      chk("t2_seq2", 32'(seq[2]), 32'd2);
      chk("t2_seq3", 32'(seq[3]), 32'd3);
      chk("t2_seq4", 32'(seq[4]), 32'd0);
    end
    chk("t2_w0", 32'(wc[0]), 32'd4);
    chk("t2_w1", 32'(wc[1]), 32'd2);
    chk("t2_w2", 32'(wc[2]), 32'd2);
    chk("t2_w3", 32'(wc[3]), 32'd2);

    // Window closes after 5 transfers
    rst();
    set_px(1, 7, 7, 3); req = 4'b0010; display = 1'b0;
    tick();
    chk("t3_grant", 32'(o_grant[0]), 32'h2);
    wcount = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (o_we[0]) wcount++; end
    display = 1'b1;
    #1;
    chk("t3_ack_drop", 32'(o_ack[0]), 32'h0);
    for (int i = 0; i < 4; i++) begin tick(); if (o_we[0]) wcount++; end
    chk("t3_writes", 32'(wcount), 32'd5);
    chk("t3_released", 32'(o_grant[0]), 32'h0);
    set_px(0, 1, 1, 1); set_px(2, 2, 2, 2); req = 4'b0111; display = 1'b0;
    tick();
    chk("t3_next_owner", 32'(o_grant[0]), 32'h4);
    req = '0; display = 1'b1;

    // Clipping
    rst();
    set_px(0, 160, 0, 1); req = 4'b0001; display = 1'b0;
    tick();
    chk("t4_ack_a", 32'(o_ack[0]), 32'h1);
    tick();
    set_px(0, 0, 120, 2);
    chk("t4_clip_a", 32'(o_clip[0]), 32'h1);
    chk("t4_we_a", 32'(o_we[0]), 32'h0);
    chk("t4_ack_b", 32'(o_ack[0]), 32'h1);
    tick();
    set_px(0, 159, 119, 6);
    chk("t4_clip_b", 32'(o_clip[0]), 32'h1);
    chk("t4_we_b", 32'(o_we[0]), 32'h0);
    tick();
    chk("t4_we_c", 32'(o_we[0]), 32'h1);
    chk("t4_addr_c", 32'(o_addr[0]), 32'd19199);
    chk("t4_clip_c", 32'(o_clip[0]), 32'h0);
    req = '0; display = 1'b1;

    // Reset mid-burst
    rst();
    set_px(2, 5, 5, 4); set_px(3, 6, 6, 7); req = 4'b0100; display = 1'b0;
    tick(); tick(); tick();
    chk("t5_midburst_we", 32'(o_we[0]), 32'h1);
    resetn = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(o_grant[0]), 32'h0);
    chk("t5_rst_we", 32'(o_we[0]), 32'h0);
    chk("t5_rst_addr", 32'(o_addr[0]), 32'h0);
    tick();
    resetn = 1'b1; req = 4'b1100;
    tick();
    chk("t5_no_partial", 32'(o_we[0]), 32'h0);
    chk("t5_grant", 32'(o_grant[0]), 32'h4);
    req = '0; display = 1'b1;

    // Vertical sync edges
    rst();
    tick();
    vs = 1'b0;
    tick();
    chk("t6_fs_pulse", 32'(o_fs[0]), 32'h1);
    tick();
    chk("t6_fs_single", 32'(o_fs[0]), 32'h0);
    vs = 1'b1;
    tick();
    chk("t6_fs_rise", 32'(o_fs[0]), 32'h0);
    tick();
    chk("t6_fs_rise2", 32'(o_fs[0]), 32'h0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/vga_fb_write_arbiter.md
Name: vga_fb_write_arbiter

Overview:
- Shares the single write port of the 160x120 pixel framebuffer between up to N_REQ drawing engines (background, volcano, scientist sprites, status overlay).
- Writes are allowed only while the VGA scan is outside the colour region (display low), so the scan-out read never collides with a write.
- Arbitration is round-robin with bounded bursts. A valid/ready handshake runs per requester.
- The block also produces a frame_start pulse that the animation sequencers use to step once per frame.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 160, framebuffer columns
- HEIGHT, 120, framebuffer rows
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- ADDR_W, 15, framebuffer address width
- COLOR_W, 3, pixel colour width
- MAX_BURST, 16, maximum pixel transfers per grant (>=1)

Ports:
- clk  in  1  system/pixel clock
- resetn  in  1  asynchronous active-low reset
- display  in  1  high while the VGA timing generator is in the colour scan region
- vga_VS  in  1  vertical sync from the timing generator, active low
- req  in  N_REQ  per-requester pixel valid
- req_x  in  N_REQ*X_W  flattened x; requester i uses bits [i*X_W +: X_W]
- req_y  in  N_REQ*Y_W  flattened y, same packing
- req_color  in  N_REQ*COLOR_W  flattened colour, same packing
- ack  out  N_REQ  per-requester ready (combinational)
- grant  out  N_REQ  one-hot current owner (registered)
- fb_we  out  1  framebuffer write enable (registered)
- fb_addr  out  ADDR_W  framebuffer write address (registered)
- fb_wdata  out  COLOR_W  framebuffer write data (registered)
- clipped  out  1  one-cycle pulse: an accepted pixel was out of range and was dropped
- frame_start  out  1  one-cycle pulse at the start of vertical sync

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, grant=0, ptr=0, beat=0.
  - fb_we=0, fb_addr=0, fb_wdata=0, clipped=0, frame_start=0.
  - vs_d=1 (registered copy of vga_VS).
  - Reset asserted mid-burst aborts the burst immediately. No partial write is issued after resetn rises.
- window = ~display.
- State IDLE:
  - If window and any req bit is high, select the first requester with req high, searching from index ptr upward with modulo-N_REQ wrap.
  - Load grant with that index one-hot, clear beat, go to GRANT.
  - Otherwise stay in IDLE with grant=0.
  - IDLE always lasts at least one cycle between grants.
- State GRANT, owner g:
  - ack[g] = window & req[g] & (beat < MAX_BURST). All other ack bits are 0. ack is 0 in IDLE.
  - A transfer occurs on a rising edge where req[g] and ack[g] are both high. beat then increments.
  - On the cycle after a transfer:
    - If req_x < WIDTH and req_y < HEIGHT: fb_we=1, fb_addr = req_y*WIDTH + req_x computed at ADDR_W bits (no overflow is possible within range), fb_wdata = req_color.
    - Otherwise: fb_we=0 and clipped=1.
  - With no transfer, fb_we=0 and clipped=0. fb_addr and fb_wdata hold their last values.
  - Write latency is exactly one cycle from transfer to fb_we.
  - Back-to-back transfers run at one per cycle. The requester presents the next pixel in the cycle after a transfer.
- Grant release:
  - Release happens on the edge where any of these holds: req[g]=0, window=0, or beat reaches MAX_BURST (the cycle after the MAX_BURST-th transfer).
  - On release: grant=0, state=IDLE, ptr=(g+1) mod N_REQ.
  - A transfer in the same cycle as the release condition is still completed. A closing window allows no further transfer.
- Data stability: the requester holds req_x, req_y and req_color stable while req is high until the transfer edge. A requester may drop req without a transfer; nothing is written.
- Simultaneous requests: only round-robin order applies, with no fixed priority. After g finishes, the lowest index at or above g+1 wins, with wrap.
- frame_start:
  - vs_d registers vga_VS every cycle.
  - frame_start = registered (vs_d & ~vga_VS): a single pulse one cycle after the falling edge of vga_VS.
  - frame_start is independent of the arbitration state.

Test Plan:
- Single requester: req[0] held with coordinates (3,2) and colour 5 during window → ack[0] in the first GRANT cycle; fb_we=1, fb_addr=323, fb_wdata=5 one cycle later; 16 consecutive writes, then IDLE for one cycle and re-grant to 0.
- All four requesters asserting continuously with MAX_BURST=2 → grant order 0,1,2,3,0; each owner gets exactly 2 writes; one idle cycle between grants.
- display rises mid-burst after 5 transfers → ack drops that cycle; exactly 5 fb_we pulses; release with ptr=owner+1; re-arbitration only after display falls.
- Out-of-range pixels x=160, y=0 and x=0, y=120 → both accepted (ack high), fb_we stays 0, clipped pulses once per pixel; an in-range (159,119) pixel gives fb_addr=19199.
- resetn pulsed low mid-burst → all outputs 0 immediately; no fb_we in the cycle after release; the next grant goes to the lowest requesting index.
- vga_VS toggling 1→0 → exactly one frame_start pulse one cycle after the fall; none on the 0→1 edge.
